// File: rtl/amba_axi_write.sv
// AXI write-channel responder: bursts of packed PCM beats into a FWFT FIFO.
// Optional per-lane write strobes when AMBA_AXI_WRITE_STRB_EN is defined.
module amba_axi_write #(
   parameter int          wordLength = 16,
   parameter int          busSize    = 4*wordLength,
   parameter int          DEPTH      = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] WIN_BYTES  = 32'h0000_1000
) (
   input  logic               aclk,
   input  logic               reset,
   input  logic [3:0]         awid,
   input  logic [31:0]        awaddr,
   input  logic [3:0]         awlen,
   input  logic               awvalid,
   output logic               awready,
   input  logic [busSize-1:0] wdata,
`ifdef AMBA_AXI_WRITE_STRB_EN
   input  logic [busSize/8-1:0] wstrb,
`endif
   input  logic               wlast,
   input  logic               wvalid,
   output logic               wready,
   output logic [3:0]         bid,
   output logic [1:0]         bresp,
   output logic               bvalid,
   input  logic               bready,
   output logic [busSize-1:0] pcm_data,
   output logic               pcm_valid,
   input  logic               pcm_ready
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LANES = busSize / wordLength;
   localparam int LB    = wordLength / 8;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]         state, state_n;
   logic [3:0]         len_q, cnt_q;
   logic               dec_q, slv_q, dec_n;
   logic [busSize-1:0] mem [DEPTH];
   logic [AW:0]        wptr, rptr, wptr_n, rptr_n, occ_n;
   logic               aw_hs, w_hs, b_hs, push, pop;
   logic               cnt_hit, last_beat, beat_slv, addr_err, burst_slv;
   logic [busSize-1:0] beat_data, head_n;
   logic [32:0]        win_lo, win_hi, start_a, end_a;

   // 33-bit math so a window or burst touching 4 GiB cannot wrap
   assign win_lo  = {1'b0, BASE_ADDR};
   assign win_hi  = win_lo + {1'b0, WIN_BYTES};
   assign start_a = {1'b0, awaddr};
   assign end_a   = start_a
                  + {23'b0, ({3'b0, awlen} + 7'd1), 3'b0}
                  - 33'd1;

   assign addr_err = (awaddr[2:0] != 3'b000)
                   || (start_a < win_lo)
                   || (start_a >= win_hi)
                   || (end_a >= win_hi);

   always_comb begin
      beat_data = wdata;
      beat_slv  = 1'b0;
`ifdef AMBA_AXI_WRITE_STRB_EN
      for (int k = 0; k < LANES; k++) begin
         if (!(&wstrb[k*LB +: LB])) begin
            beat_data[k*wordLength +: wordLength] = '0;
            if (|wstrb[k*LB +: LB])
               beat_slv = 1'b1;
         end
      end
`endif
   end

   assign aw_hs     = awvalid & awready;
   assign w_hs      = wvalid & wready;
   assign b_hs      = bvalid & bready;
   assign pop       = pcm_valid & pcm_ready;
   assign push      = w_hs & ~dec_q;
   assign cnt_hit   = (cnt_q == len_q);
   assign last_beat = w_hs & (wlast | cnt_hit);
   assign burst_slv = slv_q | beat_slv | (wlast != cnt_hit);
   assign dec_n     = aw_hs ? addr_err : dec_q;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (aw_hs)     state_n = DATA;
         DATA:    if (last_beat) state_n = RESP;
         RESP:    if (b_hs)      state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   assign wptr_n = wptr + (AW+1)'(push);
   assign rptr_n = rptr + (AW+1)'(pop);
   assign occ_n  = wptr_n - rptr_n;

   // new head bypasses the array when it is the beat being written now
   assign head_n = (rptr_n == wptr) ? beat_data
                                    : mem[rptr_n[AW-1:0]];

   always_ff @(posedge aclk) begin
      if (push)
         mem[wptr[AW-1:0]] <= beat_data;
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         state     <= IDLE;
         awready   <= 1'b0;
         wready    <= 1'b0;
         bvalid    <= 1'b0;
         bresp     <= 2'b00;
         bid       <= 4'd0;
         pcm_valid <= 1'b0;
         pcm_data  <= '0;
         wptr      <= '0;
         rptr      <= '0;
         len_q     <= 4'd0;
         cnt_q     <= 4'd0;
         dec_q     <= 1'b0;
         slv_q     <= 1'b0;
      end else begin
         state     <= state_n;
         wptr      <= wptr_n;
         rptr      <= rptr_n;
         awready   <= (state_n == IDLE);
         wready    <= (state_n == DATA) && (dec_n || occ_n != FULL);
         pcm_valid <= (occ_n != '0);
         if (occ_n != '0)
            pcm_data <= head_n;
         if (aw_hs) begin
            bid   <= awid;
            len_q <= awlen;
            cnt_q <= 4'd0;
            dec_q <= addr_err;
            slv_q <= 1'b0;
         end
         if (w_hs) begin
            if (!cnt_hit)
               cnt_q <= cnt_q + 4'd1;
            slv_q <= burst_slv;
         end
         if (last_beat) begin
            bvalid <= 1'b1;
            bresp  <= dec_q     ? 2'b11 :
                      burst_slv ? 2'b10 : 2'b00;
         end else if (b_hs) begin
            bvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_amba_axi_write.sv
// Randomised scoreboard bench for amba_axi_write.
// Expected beats/responses are queued by the driver and popped by monitors.
module tb_amba_axi_write;

   localparam int DEPTH = 8;
   localparam longint BASE = 0;
   localparam longint WIN  = 4096;
   localparam int PH_WAIT = 0;
   localparam int PH_IDLE = 1;
   localparam int PH_DATA = 2;
   localparam int PH_RESP = 3;

   logic        aclk = 1'b0;
   logic        reset;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic        awvalid, awready;
   logic [63:0] wdata;
`ifdef AMBA_AXI_WRITE_STRB_EN
   logic [7:0]  wstrb;
`endif
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [63:0] pcm_data;
   logic        pcm_valid, pcm_ready;

   amba_axi_write #(.DEPTH(DEPTH)) dut (
      .aclk(aclk), .reset(reset),
      .awid(awid), .awaddr(awaddr), .awlen(awlen),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata),
`ifdef AMBA_AXI_WRITE_STRB_EN
      .wstrb(wstrb),
`endif
      .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready)
   );

   always #5 aclk = ~aclk;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] exp_pcm [$];
   logic [5:0]  exp_b [$];
   int  ph, occ, mcnt, cur_len, pr_prob, pop_req;
   bit  cur_dec, mon_en, b_hold;
   logic [5:0]  b_prev;
   logic [63:0] last_pop;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: handshake never came", nm);
   endtask

   function automatic bit addr_bad(input logic [31:0] a, input int len);
      longint s, e;
      s = a;
      e = s + 8 * (len + 1) - 1;
      return (a[2:0] != 3'b000) || s < BASE || s >= BASE + WIN
             || e >= BASE + WIN;
   endfunction

   initial begin
      pcm_ready = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         if (pop_req > 0) begin
            pcm_ready = 1'b1;
            pop_req--;
         end else begin
            pcm_ready = ($urandom_range(99) < pr_prob);
         end
      end
   end

   // protocol-level model plus scoreboard pops, sampled mid-cycle
   always @(negedge aclk) begin
      int push, popn;
      if (mon_en) begin
         chk("awready", 64'(awready), 64'(ph == PH_IDLE));
         chk("bvalid", 64'(bvalid), 64'(ph == PH_RESP));
         chk("wready", 64'(wready),
             64'(ph == PH_DATA && (cur_dec || occ < DEPTH)));
         chk("pcm_valid", 64'(pcm_valid), 64'(occ != 0));
         if (!pcm_valid)
            chk("pcm_hold", pcm_data, last_pop);
         if (b_hold)
            chk("b_stable", {57'd0, bid, bresp, bvalid}, {57'd0, b_prev, 1'b1});
         if (pcm_valid && pcm_ready) begin
            if (exp_pcm.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL pcm_extra: got %0h expected no beat", pcm_data);
            end else begin
               chk("pcm_data", pcm_data, exp_pcm.pop_front());
            end
            last_pop = pcm_data;
         end
         if (bvalid && bready) begin
            if (exp_b.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL b_extra: got %0h expected no response",
                        {bid, bresp});
            end else begin
               chk("bid_bresp", 64'({bid, bresp}), 64'(exp_b.pop_front()));
            end
         end
         b_hold = bvalid && !bready;
         b_prev = {bid, bresp};
         push = int'(ph == PH_DATA && wvalid && wready && !cur_dec);
         popn = int'(pcm_valid && pcm_ready);
         occ  = occ + push - popn;
         case (ph)
            PH_WAIT: ph = PH_IDLE;
            PH_IDLE: if (awvalid && awready) begin
               ph = PH_DATA;
               mcnt = 0;
            end
            PH_DATA: if (wvalid && wready) begin
               if (wlast || mcnt == cur_len) ph = PH_RESP;
               else mcnt++;
            end
            PH_RESP: if (bvalid && bready) ph = PH_IDLE;
            default: ph = PH_WAIT;
         endcase
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      mon_en = 0;
      reset = 1'b1;
      awvalid = 1'b0;
      wvalid = 1'b0;
      wlast = 1'b0;
      bready = 1'b0;
      cyc(n);
      chk("rst_awready", 64'(awready), 64'(0));
      chk("rst_wready", 64'(wready), 64'(0));
      chk("rst_bvalid", 64'(bvalid), 64'(0));
      chk("rst_bresp", 64'(bresp), 64'(0));
      chk("rst_bid", 64'(bid), 64'(0));
      chk("rst_pcm_valid", 64'(pcm_valid), 64'(0));
      chk("rst_pcm_data", pcm_data, 64'(0));
      reset = 1'b0;
      exp_pcm.delete();
      exp_b.delete();
      occ = 0;
      ph = PH_WAIT;
      b_hold = 0;
      last_pop = '0;
      mon_en = 1;
   endtask

   // mode 0: wlast on beat len, 1: early wlast on beat e, 2: no wlast
   task automatic burst(input logic [31:0] addr, input int len,
                        input int mode, input int e, input int bdel,
                        input int gapmax, input bit fixed, input int abort);
      int n, t;
      bit slv, dec;
      logic [3:0]  id;
      logic [63:0] d, q;
      logic [7:0]  s;
      id = 4'($urandom_range(15));
      dec = addr_bad(addr, len);
      n = (mode == 1) ? e : len + 1;
      slv = (mode != 0);
      cur_len = len;
      cur_dec = dec;
      awaddr = addr;
      awlen = 4'(len);
      awid = id;
      awvalid = 1'b1;
      t = 0;
      do begin @(negedge aclk); t++; end while (!awready && t < 100);
      if (!awready) begin timeout("aw"); awvalid = 1'b0; return; end
      @(posedge aclk);
      #1 awvalid = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (abort >= 0 && i == abort) return;
         cyc($urandom_range(gapmax));
         d = fixed ? 64'h0004_0003_0002_0001 : {$urandom, $urandom};
         s = 8'hff;
         q = d;
`ifdef AMBA_AXI_WRITE_STRB_EN
         if ($urandom_range(7) == 0) s = 8'($urandom);
         wstrb = s;
         for (int k = 0; k < 4; k++) begin
            if (s[2*k +: 2] != 2'b11) q[16*k +: 16] = 16'h0;
            if (s[2*k +: 2] == 2'b01 || s[2*k +: 2] == 2'b10) slv = 1;
         end
`endif
         wdata = d;
         wlast = (mode == 0 && i == len) || (mode == 1 && i == e - 1);
         wvalid = 1'b1;
         if (!dec) exp_pcm.push_back(q);
         t = 0;
         do begin @(negedge aclk); t++; end while (!wready && t < 300);
         if (!wready) begin timeout("w"); wvalid = 1'b0; return; end
         @(posedge aclk);
         #1 wvalid = 1'b0;
         wlast = 1'b0;
      end
      exp_b.push_back({id, dec ? 2'b11 : slv ? 2'b10 : 2'b00});
      cyc(bdel);
      bready = 1'b1;
      t = 0;
      do begin @(negedge aclk); t++; end while (!bvalid && t < 100);
      if (!bvalid) timeout("b");
      @(posedge aclk);
      #1 bready = 1'b0;
   endtask

   initial begin
      int t, len, mode, sel;
      logic [31:0] a;
      reset = 1'b1;
      awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
      wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
`ifdef AMBA_AXI_WRITE_STRB_EN
      wstrb = 8'hff;
`endif
      pr_prob = 0; pop_req = 0; occ = 0; ph = PH_WAIT; mcnt = 0;
      cur_len = 0; cur_dec = 0; mon_en = 0; b_hold = 0;
      b_prev = '0; last_pop = '0;
      do_reset(3);

      burst(32'h0, 0, 0, 0, 0, 0, 1, -1);
      pr_prob = 100; cyc(4);
      pr_prob = 0;
      burst(32'h40, 3, 0, 0, 0, 0, 0, -1);
      pr_prob = 100; cyc(8);
      pr_prob = 0;
      fork
         burst(32'h100, 9, 0, 0, 1, 0, 0, -1);
         begin cyc(30); pop_req = 1; cyc(15); pop_req = 1; end
      join
      pr_prob = 100; cyc(16);
      burst(32'h4, 2, 0, 0, 0, 0, 0, -1);
      burst(32'h200, 3, 1, 2, 0, 0, 0, -1);
      burst(32'hff8, 1, 0, 0, 0, 0, 0, -1);
      burst(32'h300, 1, 0, 0, 5, 0, 0, -1);
      pr_prob = 0;
      burst(32'h0, 5, 0, 0, 0, 0, 0, 2);
      do_reset(1);

      for (int b = 0; b < 150; b++) begin
         pr_prob = $urandom_range(20, 100);
         len = $urandom_range(15);
         sel = $urandom_range(9);
         if (sel < 7) a = {20'd0, 9'($urandom_range(511)), 3'b000};
         else if (sel == 7) a = {20'd0, 9'($urandom_range(511)), 3'($urandom_range(1, 7))};
         else a = $urandom;
         mode = $urandom_range(9);
         mode = (mode < 7) ? 0 : (mode == 7 && len > 0) ? 1 : 2;
         burst(a, len, mode, (len > 0) ? $urandom_range(1, len) : 1,
               $urandom_range(3), $urandom_range(2), 0, -1);
      end

      pr_prob = 100;
      t = 0;
      while (exp_pcm.size() != 0 && t < 300) begin cyc(1); t++; end
      cyc(3);
      chk("leftover_pcm", 64'(exp_pcm.size()), 64'(0));
      chk("leftover_b", 64'(exp_b.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/amba_axi_write.md
Name: amba_axi_write

Overview:
- AXI-style write-channel responder that accepts bursts of packed PCM words from the system bus.
- Each 64-bit beat carries 4×16-bit samples. Accepted beats are buffered in a FIFO and streamed to the overlap-add read block with a valid/ready handshake.
- Generates one write response per burst. It is the write end of the PCM path; the overlap-add read block consumes its output.

Parameters:
- wordLength, 16, width of one PCM sample.
- busSize, 4*wordLength, data bus width (4 samples per beat).
- DEPTH, 8, FIFO depth in beats; power of two, ≥2.
- BASE_ADDR, 32'h0000_0000, start of the accepted address window.
- WIN_BYTES, 32'h0000_1000, window size in bytes.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- awid  in  4  write transaction ID.
- awaddr  in  32  burst start byte address.
- awlen  in  4  beats in burst minus 1 (0..15).
- awvalid  in  1  address valid.
- awready  out  1  address accepted.
- wdata  in  busSize  beat data; sample k at bits [(k+1)*wordLength-1 : k*wordLength].
- wlast  in  1  last beat marker.
- wvalid  in  1  data valid.
- wready  out  1  data accepted.
- bid  out  4  response ID (the latched awid).
- bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- bvalid  out  1  response valid.
- bready  in  1  response accepted.
- pcm_data  out  busSize  FIFO head beat.
- pcm_valid  out  1  FIFO non-empty.
- pcm_ready  in  1  downstream pop.

Behaviour:
- Reset (synchronous, active-high):
  - awready=0, wready=0, bvalid=0, bresp=00, bid=0, pcm_valid=0, pcm_data=0.
  - FIFO emptied; state IDLE.
  - Reset mid-burst abandons the burst silently: no B response, buffered beats discarded.
- FSM states: IDLE, DATA, RESP. All outputs are registered.
- IDLE:
  - awready=1 from the first cycle after reset deasserts.
  - On awvalid&awready: latch awid and awlen, clear the beat counter, go to DATA. awready=0 next cycle.
  - Address error when awaddr[2:0]≠0, or when awaddr, or awaddr+8*(awlen+1)-1, lies outside [BASE_ADDR, BASE_ADDR+WIN_BYTES).
- DATA:
  - wready=1 when FIFO not full, or unconditionally when an address error is latched.
  - A beat transfers on wvalid&wready. Good address: beat pushed to FIFO. Address error: beat discarded.
  - Burst ends on the first beat where counter==awlen OR wlast=1 → RESP.
  - Beat-count mismatch (wlast=1 with counter<awlen, or wlast=0 at counter==awlen) → SLVERR. Mismatched beats are still pushed.
  - Address error → DECERR, which takes priority over SLVERR.
- RESP:
  - bvalid=1 with bid and bresp; held stable until bready.
  - On bvalid&bready: bvalid=0, go IDLE; awready=1 the following cycle (minimum one idle cycle between bursts).
- FIFO:
  - First-word-fall-through. A beat pushed in cycle N is visible on pcm_valid/pcm_data in cycle N+1.
  - Pop on pcm_valid&pcm_ready.
  - Full: wready=0. A pop in the same cycle does not raise wready that cycle; it rises the next cycle.
  - Empty: pcm_valid=0, pcm_data holds its last value.
  - Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- Beat counter is 4 bits and never exceeds awlen.

Optional Feature:
- Macro AMBA_AXI_WRITE_STRB_EN.
- When defined:
  - Adds input wstrb of width busSize/8.
  - Each 16-bit sample lane is written as zero unless both of its strobe bits are 1.
  - A lane with exactly one strobe bit set → SLVERR for the burst (lane zeroed).
- When undefined: no wstrb port; all lanes are written unchanged.

Test Plan:
- Single beat: awaddr=0, awlen=0, wdata=64'h0004_0003_0002_0001, wlast=1, bready=1 → pcm_valid one cycle after the W handshake with the same data; bresp=00, bid=awid.
- 4-beat burst with pcm_ready=0 and DEPTH=8 → 4 beats buffered, wready stays 1, bresp=00. Then pcm_ready=1 pops the beats in order over 4 consecutive cycles.
- 10-beat burst (awlen=9) with pcm_ready=0 → wready drops after 8 beats. A single pop releases wready on the next cycle; bresp=00 after all 10 beats.
- awaddr=32'h4 → DECERR, no FIFO pushes, wready=1 throughout. awlen=3 with wlast on beat 2 → burst ends after 2 beats, SLVERR, 2 beats pushed.
- bready held low 5 cycles → bvalid, bid, bresp stable; awready=0 until the cycle after the B handshake. Reset asserted mid-burst → all outputs at reset values next cycle, pcm_valid=0.
